// File: rtl/btn_pkg.sv
// Shared types and counter-width helpers for the button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REPEAT
  } rpt_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop sync, debounce, registered press/release/action pulses.
// Raw-to-level latency DEBOUNCE_CYCLES+2 edges; no backpressure, events are one-cycle pulses.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 48,
  parameter int REPEAT_RATE     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic action_o
);

  localparam int CNT_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int RCNT_W = cnt_width(max2(REPEAT_DELAY, REPEAT_RATE));

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

  logic              s1_q, s2_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              action_q, action_d;
  rpt_state_t        state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              toggle;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    toggle  = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      toggle  = 1'b1;
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    press_d   = toggle & ~level_q;
    release_d = toggle & level_q;
  end

  // A release wins over a repeat that lands on the same edge.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    action_d = 1'b0;
    if (release_d) begin
      state_d = IDLE;
      rcnt_d  = '0;
    end else if (press_d) begin
      state_d  = WAIT;
      rcnt_d   = '0;
      action_d = 1'b1;
    end else begin
      case (state_q)
        WAIT: begin
          if (rcnt_q == DELAY_LAST) begin
            state_d  = REPEAT;
            rcnt_d   = '0;
            action_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
          end
        end
        REPEAT: begin
          if (rcnt_q == RATE_LAST) begin
            rcnt_d   = '0;
            action_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      action_q  <= 1'b0;
      state_q   <= IDLE;
      rcnt_q    <= '0;
    end else begin
      s1_q      <= raw_i;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      action_q  <= action_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign action_o  = action_q;

endmodule

// File: rtl/btn_conditioner.sv
// NUM_BTN independent debounced button channels with auto-repeat.
// Latency DEBOUNCE_CYCLES+2 edges raw-to-level; no backpressure, all outputs are flops.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 48,
  parameter int REPEAT_RATE     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_action
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .action_o (btn_action[i])
    );
  end

endmodule
